// File: rtl/alu_sequencer.sv
// Multi-cycle execute controller for a shared 8-bit ALU: turns macro-ops
// (ADD/SUB/AND/OR/NOT/NEG/MUL) into one or more ALU passes behind valid/ready handshakes.
module alu_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_inv,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic             res_zero,
  output logic             res_err,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PASS1 = 3'd1,
    S_PASS2 = 3'd2,
    S_MUL   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_NEG = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;     // operand A, reused as shifting multiplicand M
  logic [WIDTH-1:0] b_q, b_d;     // operand B, reused as shifting multiplier Q
  logic [WIDTH-1:0] p_q, p_d;     // SUB intermediate t, or MUL product P
  logic             c1_q, c1_d;
  logic [WIDTH-1:0] tok_q, tok_d; // one-hot iteration token, avoids a counter adder
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic             alu_inv_q, alu_inv_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_carry_q, res_carry_d, res_zero_q, res_zero_d, res_err_q, res_err_d;
  logic             load_res;
  logic [WIDTH-1:0] p_nxt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = cmd_valid ? S_PASS1 : S_IDLE;
      S_PASS1: begin
        if (op_q == OP_SUB) begin
          state_d = S_PASS2;
        end else if (op_q == OP_MUL) begin
          state_d = S_MUL;
        end else begin
          state_d = S_DONE;
        end
      end
      S_PASS2: state_d = S_DONE;
      S_MUL:   state_d = tok_q[WIDTH-1] ? S_DONE : S_MUL;
      S_DONE:  state_d = res_ready ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath, ALU drive and result next values; ALU inputs return to zero whenever no pass follows
  always_comb begin
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    p_d         = p_q;
    c1_d        = c1_q;
    tok_d       = tok_q;
    alu_a_d     = ZERO;
    alu_b_d     = ZERO;
    alu_inv_d   = 1'b0;
    alu_op_d    = 2'b00;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    res_err_d   = res_err_q;
    load_res    = 1'b0;
    p_nxt       = b_q[0] ? alu_result : p_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d  = cmd_op;
          a_d   = cmd_a;
          b_d   = cmd_b;
          p_d   = ZERO;
          c1_d  = 1'b0;
          tok_d = ONE;
          case (cmd_op)
            OP_ADD: begin alu_a_d = cmd_a; alu_b_d = cmd_b; end
            OP_SUB: begin alu_a_d = cmd_b; alu_b_d = cmd_a; alu_inv_d = 1'b1; end
            OP_AND: begin alu_a_d = cmd_a; alu_b_d = cmd_b; alu_op_d = 2'b01; end
            OP_OR:  begin alu_a_d = cmd_a; alu_b_d = cmd_b; alu_op_d = 2'b10; end
            OP_NOT: begin alu_a_d = cmd_a; alu_inv_d = 1'b1; end
            OP_NEG: begin alu_a_d = cmd_a; alu_b_d = ONE; alu_inv_d = 1'b1; end
            default: begin alu_a_d = ZERO; end
          endcase
        end else begin
          op_d = op_q;
        end
      end
      S_PASS1: begin
        if (op_q == OP_SUB) begin
          p_d     = alu_result;
          c1_d    = alu_cout;
          alu_a_d = alu_result;
          alu_b_d = ONE;
        end else if (op_q == OP_MUL) begin
          alu_a_d = p_q;
          alu_b_d = a_q;
        end else begin
          load_res    = 1'b1;
          res_err_d   = (op_q == 3'b111);
          res_data_d  = (op_q == 3'b111) ? ZERO : alu_result;
          res_carry_d = ((op_q == OP_ADD) || (op_q == OP_NEG)) ? alu_cout : 1'b0;
        end
      end
      S_PASS2: begin
        load_res    = 1'b1;
        res_data_d  = alu_result;
        res_carry_d = c1_q | alu_cout;
        res_err_d   = 1'b0;
      end
      S_MUL: begin
        p_d   = p_nxt;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        tok_d = tok_q << 1;
        if (tok_q[WIDTH-1]) begin
          load_res    = 1'b1;
          res_data_d  = p_nxt;
          res_carry_d = 1'b0;
          res_err_d   = 1'b0;
        end else begin
          alu_a_d = p_nxt;
          alu_b_d = a_q << 1;
        end
      end
      S_DONE: begin
        load_res = 1'b0;
      end
      default: begin
        load_res = 1'b0;
      end
    endcase
    res_zero_d = load_res ? (res_data_d == ZERO) : res_zero_q;
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= 3'b000;
      a_q         <= ZERO;
      b_q         <= ZERO;
      p_q         <= ZERO;
      c1_q        <= 1'b0;
      tok_q       <= ZERO;
      alu_a_q     <= ZERO;
      alu_b_q     <= ZERO;
      alu_inv_q   <= 1'b0;
      alu_op_q    <= 2'b00;
      res_data_q  <= ZERO;
      res_carry_q <= 1'b0;
      res_zero_q  <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      p_q         <= p_d;
      c1_q        <= c1_d;
      tok_q       <= tok_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_inv_q   <= alu_inv_d;
      alu_op_q    <= alu_op_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      res_zero_q  <= res_zero_d;
      res_err_q   <= res_err_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_inv   = alu_inv_q;
  assign alu_op    = alu_op_q;
  assign res_data  = res_data_q;
  assign res_carry = res_carry_q;
  assign res_zero  = res_zero_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural model of the shared ALU.
module tb_alu_sequencer;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid, cmd_ready, res_valid, res_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a, cmd_b, alu_a, alu_b, alu_result, res_data;
  logic             alu_inv, alu_cout, res_carry, res_zero, res_err, busy;
  logic [1:0]       alu_op;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             carry;
    logic             zero;
    logic             err;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  alu_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_inv(alu_inv), .alu_op(alu_op),
    .alu_result(alu_result), .alu_cout(alu_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_carry(res_carry), .res_zero(res_zero), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural shared ALU
  logic [WIDTH-1:0] a_eff;
  logic [WIDTH:0]   sum;
  assign a_eff = alu_inv ? ~alu_a : alu_a;
  assign sum   = {1'b0, a_eff} + {1'b0, alu_b};
  always_comb begin
    alu_cout = 1'b0;
    case (alu_op)
      2'b00: begin alu_result = sum[WIDTH-1:0]; alu_cout = sum[WIDTH]; end
      2'b01: alu_result = a_eff & alu_b;
      2'b10: alu_result = a_eff | alu_b;
      default: alu_result = a_eff;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    logic [WIDTH:0] s;
    logic [2*WIDTH-1:0] pr;
    e.carry = 1'b0;
    e.err   = 1'b0;
    e.data  = '0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; e.data = s[WIDTH-1:0]; e.carry = s[WIDTH]; end
      3'd1: begin e.data = a - b; e.carry = (a >= b); end
      3'd2: e.data = a & b;
      3'd3: e.data = a | b;
      3'd4: e.data = ~a;
      3'd5: begin e.data = -a; e.carry = (a == '0); end
      3'd6: begin pr = a * b; e.data = pr[WIDTH-1:0]; end
      default: e.err = 1'b1;
    endcase
    e.zero = (e.data == '0);
    return e;
  endfunction

  function automatic int lat_of(input logic [2:0] op);
    return (op == 3'd1) ? 3 : (op == 3'd6) ? WIDTH + 2 : 2;
  endfunction

  task automatic run(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int hold);
    exp_t e;
    int n;
    logic [WIDTH-1:0] p, m, q;
    sb.push_back(model(op, a, b));
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    res_ready = (hold == 0);
    check("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 1; p = '0; m = a; q = b;
    while (!res_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (op == 3'd6 && n >= 2 && n <= WIDTH + 1) begin
        check("mul_alu_a", alu_a, p);
        check("mul_alu_b", alu_b, m);
        if (q[0]) p = p + m;
        m = m << 1;
        q = q >> 1;
      end
      if (op == 3'd7 && n == 2) check("ill_alu_idle", {alu_a, alu_b, alu_inv, alu_op}, 0);
    end
    check("latency", n, lat_of(op));
    e = sb.pop_front();
    check("res_data", res_data, e.data);
    check("res_carry", res_carry, e.carry);
    check("res_zero", res_zero, e.zero);
    check("res_err", res_err, e.err);
    check("done_alu_idle", {alu_a, alu_b, alu_inv, alu_op}, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 3'd0;
      @(posedge clk); #1;
      check("hold_valid", res_valid, 1);
      check("hold_ready", cmd_ready, 0);
      check("hold_data", res_data, e.data);
    end
    if (hold > 0) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      res_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("consumed_valid", res_valid, 0);
    check("consumed_busy", busy, 0);
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = '0; cmd_b = '0; res_ready = 1'b1;
    #12;
    check("rst_ready", cmd_ready, 1);
    check("rst_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_res", {res_data, res_carry, res_zero, res_err}, 0);
    check("rst_alu", {alu_a, alu_b, alu_inv, alu_op}, 0);
    @(negedge clk); rst_n = 1'b1;

    run(3'd0, 8'h05, 8'h03, 0);
    run(3'd0, 8'hFF, 8'h01, 0);
    run(3'd1, 8'h05, 8'h03, 0);
    run(3'd1, 8'h03, 8'h05, 0);
    run(3'd1, 8'h07, 8'h07, 0);
    run(3'd2, 8'h0F, 8'h33, 0);
    run(3'd3, 8'h0F, 8'h33, 0);
    run(3'd4, 8'hAA, 8'h00, 0);
    run(3'd5, 8'h01, 8'h00, 0);
    run(3'd5, 8'h00, 8'h00, 0);
    run(3'd6, 8'h0D, 8'h0B, 0);
    run(3'd6, 8'h10, 8'h10, 0);
    run(3'd0, 8'h12, 8'h34, 5);
    run(3'd1, 8'h80, 8'h01, 0);
    run(3'd7, 8'h5A, 8'hA5, 0);

    // Reset during the fourth multiply iteration
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd6; cmd_a = 8'h0D; cmd_b = 8'h0B;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_ready", cmd_ready, 1);
    check("mrst_valid", res_valid, 0);
    check("mrst_alu", {alu_a, alu_b, alu_inv, alu_op}, 0);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (res_valid) seen = 1'b1;
    end
    check("mrst_no_result", seen, 0);
    run(3'd0, 8'h21, 8'h12, 0);

    for (int i = 0; i < 12; i++) begin
      run(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 0);
    end
    check("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
